// File: rtl/phase_sequencer_if.sv
// Core <-> phase sequencer bundle: decoder inputs, exec/step, strobes.
// The step signal exists only when STEP_MODE_EN is defined.
interface phase_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             exec;
  logic [15:0]      instr;
  logic             reg_write;
  logic             pc_src;
`ifdef STEP_MODE_EN
  logic             step;
`endif
  logic [4:0]       phase;
  logic             ir_load;
  logic             pc_inc;
  logic             pc_branch;
  logic             mem_rd;
  logic             mem_wr;
  logic             rf_we;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] retired;

`ifdef STEP_MODE_EN
  modport master (
    output exec, instr, reg_write, pc_src, step,
    input  phase, ir_load, pc_inc, pc_branch, mem_rd,
    input  mem_wr, rf_we, running, halted, retired
  );
  modport slave (
    input  exec, instr, reg_write, pc_src, step,
    output phase, ir_load, pc_inc, pc_branch, mem_rd,
    output mem_wr, rf_we, running, halted, retired
  );
`else
  modport master (
    output exec, instr, reg_write, pc_src,
    input  phase, ir_load, pc_inc, pc_branch, mem_rd,
    input  mem_wr, rf_we, running, halted, retired
  );
  modport slave (
    input  exec, instr, reg_write, pc_src,
    output phase, ir_load, pc_inc, pc_branch, mem_rd,
    output mem_wr, rf_we, running, halted, retired
  );
`endif
endinterface

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer with exec run/stop and sticky HLT.
// Optional single-step input enabled by defining STEP_MODE_EN.
module phase_sequencer #(
  parameter int CNT_W = 16
) (
  input logic              clock,
  input logic              reset,
  phase_sequencer_if.slave bus
);

  // One-hot states so the phase output is the register itself
  typedef enum logic [5:0] {
    IDLE = 6'b000000,
    P1   = 6'b000001,
    P2   = 6'b000010,
    P3   = 6'b000100,
    P4   = 6'b001000,
    P5   = 6'b010000,
    HALT = 6'b100000
  } state_t;

  state_t           state_q, state_d;
  logic             exec_q;
  logic             stop_q, stop_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             exec_rise;
  logic             step_rise;
  logic             is_hlt;

  assign exec_rise = bus.exec & ~exec_q;
  assign is_hlt    = (bus.instr[15:14] == 2'b11) &&
                     (bus.instr[7:4] == 4'hf);

`ifdef STEP_MODE_EN
  logic step_q;

  assign step_rise = bus.step & ~step_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= bus.step;
    end
  end
`else
  assign step_rise = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    stop_d    = stop_q;
    retired_d = retired_q;
    unique case (state_q)
      IDLE: begin
        if (exec_rise) begin
          state_d = P1;
        end else if (step_rise) begin
          // a single step is a run with the stop already requested
          state_d = P1;
          stop_d  = 1'b1;
        end
      end
      P1, P2, P3, P4: begin
        state_d = state_t'(state_q << 1);
        stop_d  = stop_q | exec_rise;
      end
      P5: begin
        stop_d    = 1'b0;
        retired_d = retired_q + CNT_W'(1);
        if (is_hlt) begin
          state_d = HALT;
        end else if (stop_q | exec_rise) begin
          state_d = IDLE;
        end else begin
          state_d = P1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      exec_q    <= 1'b0;
      stop_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      exec_q    <= bus.exec;
      stop_q    <= stop_d;
      retired_q <= retired_d;
    end
  end

  assign bus.phase     = state_q[4:0];
  assign bus.running   = |state_q[4:0];
  assign bus.halted    = state_q[5];
  assign bus.retired   = retired_q;
  assign bus.ir_load   = state_q == P1;
  assign bus.pc_inc    = state_q == P1;
  assign bus.mem_rd    = (state_q == P4) &&
                         (bus.instr[15:14] == 2'b00);
  assign bus.mem_wr    = (state_q == P4) &&
                         (bus.instr[15:14] == 2'b01);
  assign bus.rf_we     = (state_q == P5) & bus.reg_write;
  assign bus.pc_branch = (state_q == P5) & bus.pc_src;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: per-cycle plans of stimulus
// and expected outputs, compared on the falling clock edge.
module tb_phase_sequencer;

  localparam logic [15:0] LI  = 16'h8005;
  localparam logic [15:0] ADD = 16'h8120;
  localparam logic [15:0] LD  = 16'h0230;
  localparam logic [15:0] ST  = 16'h4340;
  localparam logic [15:0] BR  = 16'hc010;
  localparam logic [15:0] HLT = 16'hc0f0;

  typedef struct packed {
    logic [4:0]  phase;
    logic        ir_load;
    logic        pc_inc;
    logic        pc_branch;
    logic        mem_rd;
    logic        mem_wr;
    logic        rf_we;
    logic        running;
    logic        halted;
    logic [15:0] retired;
  } obs_t;

  typedef struct packed {
    logic        exe;
    logic        stp;
    logic [15:0] ins;
    logic        rw;
    logic        ps;
  } stim_t;

  logic  clock;
  logic  reset;
  int    vecs;
  int    miss;
  stim_t st_q[$];
  obs_t  pl_q[$];
  obs_t  exp_q[$];

  phase_sequencer_if #(.CNT_W(16)) bus ();

  phase_sequencer #(.CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic obs_t mk(int ph, logic [15:0] ins,
                              logic rw, logic ps,
                              int ret, logic halt);
    obs_t o;
    o = '0;
    if (ph > 0) o.phase = 5'(1 << (ph - 1));
    o.ir_load   = ph == 1;
    o.pc_inc    = ph == 1;
    o.mem_rd    = (ph == 4) && (ins[15:14] == 2'b00);
    o.mem_wr    = (ph == 4) && (ins[15:14] == 2'b01);
    o.rf_we     = (ph == 5) && rw;
    o.pc_branch = (ph == 5) && ps;
    o.running   = ph > 0;
    o.halted    = halt;
    o.retired   = 16'(ret);
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.phase     = bus.phase;
    o.ir_load   = bus.ir_load;
    o.pc_inc    = bus.pc_inc;
    o.pc_branch = bus.pc_branch;
    o.mem_rd    = bus.mem_rd;
    o.mem_wr    = bus.mem_wr;
    o.rf_we     = bus.rf_we;
    o.running   = bus.running;
    o.halted    = bus.halted;
    o.retired   = bus.retired;
    return o;
  endfunction

  task automatic apply(input stim_t s);
    bus.exec      = s.exe;
    bus.instr     = s.ins;
    bus.reg_write = s.rw;
    bus.pc_src    = s.ps;
`ifdef STEP_MODE_EN
    bus.step      = s.stp;
`endif
  endtask

  task automatic plan(input logic exe, input logic stp,
                      input logic [15:0] ins, input logic rw,
                      input logic ps, input int ph,
                      input int ret, input logic halt);
    stim_t s;
    s = '{exe: exe, stp: stp, ins: ins, rw: rw, ps: ps};
    st_q.push_back(s);
    pl_q.push_back(mk(ph, ins, rw, ps, ret, halt));
  endtask

  task automatic instr5(input logic [15:0] ins, input logic rw,
                        input logic ps, input int ret,
                        input logic [4:0] exe_m,
                        input logic [4:0] stp_m);
    for (int p = 1; p <= 5; p++) begin
      plan(exe_m[p-1], stp_m[p-1], ins, rw, ps, p, ret, 1'b0);
    end
  endtask

  task automatic apply_reset();
    apply('0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, e;
    stim_t s;
    s = '{exe: 1'b1, stp: 1'b1, ins: ST, rw: 1'b1, ps: 1'b1};
    reset = 1'b1;
    apply(s);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(0, ST, 1'b1, 1'b1, 0, 1'b0));
      @(negedge clock);
      got = observe();
      e = exp_q.pop_front();
      vecs++;
      if (got !== e) begin
        miss++;
        $display("FAIL reset cyc%0d got=%h exp=%h", i, got, e);
      end
    end
    @(posedge clock);
    #1;
    apply('0);
    reset = 1'b0;
  endtask

  task automatic test_program();
    obs_t got, e;
    int n;
    n = 0;
    apply_reset();
    plan(1'b1, 1'b0, LI, 1'b1, 1'b0, 0, 0, 1'b0);
    instr5(LI, 1'b1, 1'b0, 0, 5'b0, 5'b0);
    instr5(ADD, 1'b1, 1'b0, 1, 5'b0, 5'b0);
    instr5(HLT, 1'b0, 1'b0, 2, 5'b0, 5'b0);
    plan(1'b0, 1'b0, HLT, 1'b0, 1'b0, 0, 3, 1'b1);
    plan(1'b1, 1'b0, HLT, 1'b0, 1'b0, 0, 3, 1'b1);
    plan(1'b0, 1'b0, HLT, 1'b0, 1'b0, 0, 3, 1'b1);
    plan(1'b0, 1'b0, HLT, 1'b0, 1'b0, 0, 3, 1'b1);
    while (st_q.size() > 0) begin
      apply(st_q.pop_front());
      exp_q.push_back(pl_q.pop_front());
      @(negedge clock);
      got = observe();
      e = exp_q.pop_front();
      vecs++;
      if (got !== e) begin
        miss++;
        $display("FAIL program cyc%0d got=%h exp=%h", n, got, e);
      end
      n++;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_exec_hold();
    obs_t got, e;
    int n;
    n = 0;
    apply_reset();
    plan(1'b1, 1'b0, ADD, 1'b1, 1'b0, 0, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      instr5(ADD, 1'b1, 1'b0, k, 5'b11111, 5'b0);
    end
    instr5(ADD, 1'b1, 1'b0, 3, 5'b01111, 5'b0);
    instr5(ADD, 1'b1, 1'b0, 4, 5'b00001, 5'b0);
    plan(1'b0, 1'b0, ADD, 1'b1, 1'b0, 0, 5, 1'b0);
    while (st_q.size() > 0) begin
      apply(st_q.pop_front());
      exp_q.push_back(pl_q.pop_front());
      @(negedge clock);
      got = observe();
      e = exp_q.pop_front();
      vecs++;
      if (got !== e) begin
        miss++;
        $display("FAIL exec_hold cyc%0d got=%h exp=%h", n, got, e);
      end
      n++;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_mem();
    obs_t got, e;
    int n;
    n = 0;
    apply_reset();
    plan(1'b1, 1'b0, LD, 1'b1, 1'b0, 0, 0, 1'b0);
    instr5(LD, 1'b1, 1'b0, 0, 5'b0, 5'b0);
    instr5(ST, 1'b0, 1'b0, 1, 5'b10000, 5'b0);
    plan(1'b0, 1'b0, ST, 1'b0, 1'b0, 0, 2, 1'b0);
    plan(1'b0, 1'b0, ST, 1'b0, 1'b0, 0, 2, 1'b0);
    while (st_q.size() > 0) begin
      apply(st_q.pop_front());
      exp_q.push_back(pl_q.pop_front());
      @(negedge clock);
      got = observe();
      e = exp_q.pop_front();
      vecs++;
      if (got !== e) begin
        miss++;
        $display("FAIL mem cyc%0d got=%h exp=%h", n, got, e);
      end
      n++;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_branch_stop();
    obs_t got, e;
    int n;
    n = 0;
    apply_reset();
    plan(1'b1, 1'b0, BR, 1'b0, 1'b1, 0, 0, 1'b0);
    instr5(BR, 1'b0, 1'b1, 0, 5'b0, 5'b0);
    instr5(ADD, 1'b1, 1'b0, 1, 5'b00100, 5'b0);
    plan(1'b0, 1'b0, ADD, 1'b1, 1'b0, 0, 2, 1'b0);
    plan(1'b0, 1'b0, ADD, 1'b1, 1'b0, 0, 2, 1'b0);
    while (st_q.size() > 0) begin
      apply(st_q.pop_front());
      exp_q.push_back(pl_q.pop_front());
      @(negedge clock);
      got = observe();
      e = exp_q.pop_front();
      vecs++;
      if (got !== e) begin
        miss++;
        $display("FAIL branch_stop cyc%0d got=%h exp=%h", n, got, e);
      end
      n++;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, e;
    stim_t s;
    int n;
    n = 0;
    apply_reset();
    plan(1'b1, 1'b0, LI, 1'b1, 1'b0, 0, 0, 1'b0);
    instr5(LI, 1'b1, 1'b0, 0, 5'b0, 5'b0);
    for (int p = 1; p <= 4; p++) begin
      plan(1'b0, 1'b0, ST, 1'b0, 1'b0, p, 1, 1'b0);
    end
    while (st_q.size() > 0) begin
      apply(st_q.pop_front());
      exp_q.push_back(pl_q.pop_front());
      @(negedge clock);
      got = observe();
      e = exp_q.pop_front();
      vecs++;
      if (got !== e) begin
        miss++;
        $display("FAIL reset_mid cyc%0d got=%h exp=%h", n, got, e);
      end
      n++;
      if (st_q.size() > 0) begin
        @(posedge clock);
        #1;
      end
    end
    // still inside P4 of ST: reset must clear it before any edge
    #2;
    reset = 1'b1;
    exp_q.push_back(mk(0, ST, 1'b0, 1'b0, 0, 1'b0));
    #1;
    got = observe();
    e = exp_q.pop_front();
    vecs++;
    if (got !== e) begin
      miss++;
      $display("FAIL reset_mid async got=%h exp=%h", got, e);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    s = '{exe: 1'b0, stp: 1'b0, ins: ST, rw: 1'b0, ps: 1'b0};
    apply(s);
    exp_q.push_back(mk(0, ST, 1'b0, 1'b0, 0, 1'b0));
    @(negedge clock);
    got = observe();
    e = exp_q.pop_front();
    vecs++;
    if (got !== e) begin
      miss++;
      $display("FAIL reset_mid after got=%h exp=%h", got, e);
    end
    @(posedge clock);
    #1;
  endtask

`ifdef STEP_MODE_EN
  task automatic test_step();
    obs_t got, e;
    int n;
    n = 0;
    apply_reset();
    plan(1'b0, 1'b1, ADD, 1'b1, 1'b0, 0, 0, 1'b0);
    instr5(ADD, 1'b1, 1'b0, 0, 5'b0, 5'b00010);
    plan(1'b0, 1'b0, ADD, 1'b1, 1'b0, 0, 1, 1'b0);
    plan(1'b0, 1'b0, ADD, 1'b1, 1'b0, 0, 1, 1'b0);
    plan(1'b1, 1'b1, ADD, 1'b1, 1'b0, 0, 1, 1'b0);
    instr5(ADD, 1'b1, 1'b0, 1, 5'b0, 5'b0);
    instr5(ADD, 1'b1, 1'b0, 2, 5'b00001, 5'b0);
    plan(1'b0, 1'b0, ADD, 1'b1, 1'b0, 0, 3, 1'b0);
    while (st_q.size() > 0) begin
      apply(st_q.pop_front());
      exp_q.push_back(pl_q.pop_front());
      @(negedge clock);
      got = observe();
      e = exp_q.pop_front();
      vecs++;
      if (got !== e) begin
        miss++;
        $display("FAIL step cyc%0d got=%h exp=%h", n, got, e);
      end
      n++;
      @(posedge clock);
      #1;
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    vecs  = 0;
    miss  = 0;
    reset = 1'b1;
    apply('0);
    test_reset();
    test_program();
    test_exec_hold();
    test_mem();
    test_branch_stop();
    test_reset_mid();
`ifdef STEP_MODE_EN
    test_step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Multi-cycle phase sequencer for the 16-bit core. Steps each instruction through five phases: P1 fetch, P2 decode/register read, P3 ALU, P4 memory, P5 writeback. It gates the core's write enables and branch strobe, handles run/stop from the exec button, and stops on HLT. It sits beside the combinational instruction decoder and consumes that decoder's RegWrite and PCSrc outputs.

Parameters:
CNT_W, 16, width of the retired-instruction counter.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
exec  in  1  run/stop request, level from a debounced button; rising edge is the event
instr  in  16  current IR contents; valid from P2 onward
reg_write  in  1  RegWrite from the decoder
pc_src  in  1  PCSrc from the decoder
phase  out  5  one-hot phase: bit0=P1 … bit4=P5; 0 when not running
ir_load  out  1  latch instruction into IR
pc_inc  out  1  PC <= PC+1
pc_branch  out  1  PC <= branch target
mem_rd  out  1  data-memory read enable (LD)
mem_wr  out  1  data-memory write enable (ST)
rf_we  out  1  register-file write enable
running  out  1  sequencer in P1..P5
halted  out  1  sticky HLT status
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset is asynchronous and active-high. Reset values: state=IDLE, phase=0, all strobes 0, running=0, halted=0, retired=0, exec edge register=0.
- Exec edge: exec_q is registered each cycle; exec_rise = exec & ~exec_q. Holding exec high produces exactly one event.
- States: IDLE, P1, P2, P3, P4, P5, HALT. Each phase lasts one cycle, so one instruction takes 5 cycles.
- IDLE: on exec_rise go to P1; otherwise stay.
- P1→P2→P3→P4→P5 unconditionally.
- P5 transitions, in priority order:
  - instr is HLT (instr[15:14]=11, instr[7:4]=1111) → HALT.
  - stop_pending → IDLE.
  - otherwise → P1.
- stop_pending: set by exec_rise in any of P1..P5. Cleared on leaving P5. The current instruction always completes; there is no mid-instruction stop.
- exec_rise in the same cycle as P5: it sets stop_pending combinationally for that P5 decision, so the next state is IDLE (HLT still has priority).
- HALT: halted=1 and running=0. exec_rise is ignored; only reset leaves HALT.
- Strobes are combinational from the state register and instr, asserted for exactly one cycle per instruction:
  - ir_load = P1.
  - pc_inc = P1.
  - mem_rd = P4 & instr[15:14]==00.
  - mem_wr = P4 & instr[15:14]==01.
  - rf_we = P5 & reg_write.
  - pc_branch = P5 & pc_src.
  - All strobes are 0 in IDLE and HALT.
- phase is the one-hot state encoding. running = |phase.
- retired increments on every P5→next transition, HLT included. It wraps modulo 2^CNT_W with no saturation.
- Reset mid-instruction: the sequencer returns to IDLE immediately. Any in-flight strobe deasserts asynchronously.

Optional Feature:
Macro STEP_MODE_EN.
- Defined: adds input port `step` (1 bit), with internal edge detection matching exec. A step rising edge in IDLE runs exactly one instruction: P1..P5, then IDLE (or HALT if the instruction is HLT). A step edge while running is ignored. If exec_rise and step_rise arrive in the same IDLE cycle, exec wins and the core runs continuously.
- Not defined: no `step` port, no single-step logic.

Test Plan:
- Reset, then exec pulse with IR sequence LI, ADD, HLT → phase cycles 1,2,4,8,16 per instruction. retired=3 after 15 cycles. halted=1. A later exec pulse leaves state in HALT.
- Hold exec high for 20 cycles while IR=ADD (reg_write=1) → only one start event. rf_we pulses once every 5 cycles, in P5 only.
- LD then ST instructions → mem_rd=1 only in P4 of LD; mem_wr=1 only in P4 of ST; neither asserts in any other phase.
- Branch with pc_src=1 → pc_branch=1 in P5 and pc_inc=1 in P1. Exec pulse in P3 → instruction completes, state=IDLE after P5, retired increments by 1.
- Assert reset during P4 of ST → mem_wr drops the same cycle without waiting for a clock edge. All outputs return to reset values. retired=0.
- With STEP_MODE_EN, step pulse in IDLE with IR=ADD → exactly one P1..P5 pass, then IDLE, retired=1. A step pulse during P2 has no effect.
